// File: rtl/bus_fabric.sv
// Single-master bus fabric: decodes address bits [31:28] to a slave slot and
// runs each access with handshake or fixed wait states, a timeout and fault reporting.
module bus_fabric #(
  parameter int                   NSLAVES    = 8,
  parameter int                   DW         = 32,
  parameter logic [NSLAVES*4-1:0] FIXED_WAIT = '0,
  parameter int                   TIMEOUT    = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             m_address,
  input  logic                    m_read,
  input  logic                    m_write,
  output logic [DW-1:0]           m_readdata,
  output logic                    m_wait,
  output logic                    m_fault,
  output logic [NSLAVES-1:0]      s_read,
  output logic [NSLAVES-1:0]      s_write,
  input  logic [NSLAVES-1:0]      s_wait,
  input  logic [NSLAVES*DW-1:0]   s_readdata,
  output logic [3:0]              chipselect,
  output logic [7:0]              fault_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    slot_q, slot_d;
  logic          write_q, write_d;
  logic [9:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [7:0]    faults_q, faults_d;

  logic          request;
  logic          slotValid;
  logic          selWait;
  logic [3:0]    selFixed;
  logic [DW-1:0] selData;
  logic          complete;
  logic [7:0]    faultsInc;
  logic          unusedAddrBits;

  assign request        = m_read | m_write;
  assign slotValid      = {1'b0, m_address[31:28]} < 5'(NSLAVES);
  assign faultsInc      = (faults_q == 8'hFF) ? faults_q : faults_q + 8'd1;
  assign unusedAddrBits = ^m_address[27:0];

  always_comb begin
    selWait  = 1'b1;
    selFixed = '0;
    selData  = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (slot_q == 4'(i)) begin
        selWait  = s_wait[i];
        selFixed = FIXED_WAIT[i*4 +: 4];
        selData  = s_readdata[i*DW +: DW];
      end
    end
  end

  // A nonzero fixed wait count overrides the slave's own stall line.
  assign complete = (selFixed != 4'd0) ? (cnt_q == {6'd0, selFixed}) : !selWait;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      write_q  <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      faults_q <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      write_q  <= write_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      faults_q <= faults_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    write_d  = write_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    faults_d = faults_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m_read && m_write) begin
          state_d  = FAULT;
          rdata_d  = '0;
          faults_d = faultsInc;
        end else if (request) begin
          slot_d  = m_address[31:28];
          write_d = m_write;
          if (slotValid) begin
            state_d = ACCESS;
            cnt_d   = 10'd1;
          end else begin
            state_d  = FAULT;
            rdata_d  = '0;
            faults_d = faultsInc;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 10'd1;
        // Withdrawal wins, then completion, then timeout.
        if (!request) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (complete) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!write_q) rdata_d = selData;
        end else if (cnt_q == 10'(TIMEOUT)) begin
          state_d  = FAULT;
          cnt_d    = '0;
          rdata_d  = '0;
          faults_d = faultsInc;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_read  = '0;
    s_write = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if ((state_q == ACCESS) && request && (slot_q == 4'(i))) begin
        s_read[i]  = !write_q;
        s_write[i] = write_q;
      end
    end
  end

  assign m_wait      = request && !reset && ((state_q == IDLE) || (state_q == ACCESS));
  assign m_fault     = (state_q == FAULT);
  assign m_readdata  = rdata_q;
  assign chipselect  = slot_q;
  assign fault_count = faults_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Randomized self-checking bench for bus_fabric: a transaction-level model
// predicts each cycle's outputs, plus directed scenarios with literal expectations.
module tb_bus_fabric;

  localparam int          NSL = 8;
  localparam int          TO  = 16;
  localparam logic [31:0] FW  = 32'h0060_0030;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   m_address;
  logic          m_read, m_write;
  logic [31:0]   m_readdata;
  logic          m_wait, m_fault;
  logic [7:0]    s_read, s_write, s_wait;
  logic [255:0]  s_readdata;
  logic [3:0]    chipselect;
  logic [7:0]    fault_count;

  int            checks = 0;
  int            failures = 0;
  int            strobeCycles = 0;
  bit            expValid = 1'b0;
  logic [7:0]    expRd, expWr;
  logic          expWait, expFault;
  logic [31:0]   modelData;
  logic [3:0]    modelCs;
  int            modelFc;

  bus_fabric #(.NSLAVES(NSL), .DW(32), .FIXED_WAIT(FW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .m_address(m_address), .m_read(m_read),
    .m_write(m_write), .m_readdata(m_readdata), .m_wait(m_wait), .m_fault(m_fault),
    .s_read(s_read), .s_write(s_write), .s_wait(s_wait), .s_readdata(s_readdata),
    .chipselect(chipselect), .fault_count(fault_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if ((|s_read) || (|s_write)) strobeCycles++;
    if (expValid) begin
      checkOutput("s_read", {24'd0, s_read}, {24'd0, expRd});
      checkOutput("s_write", {24'd0, s_write}, {24'd0, expWr});
      checkOutput("m_wait", {31'd0, m_wait}, {31'd0, expWait});
      checkOutput("m_fault", {31'd0, m_fault}, {31'd0, expFault});
      checkOutput("m_readdata", m_readdata, modelData);
      checkOutput("chipselect", {28'd0, chipselect}, {28'd0, modelCs});
      checkOutput("fault_count", {24'd0, fault_count}, 32'(modelFc));
    end
  end

  // One whole transaction: its fate (done, fault or withdrawn) and length are
  // worked out up front, then each cycle's expected outputs follow from them.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [3:0] slot,
                               input int hsLow, input int withdrawAt,
                               input logic [31:0] slotData, output int releaseCyc);
    logic [31:0]  fwVec;
    logic [255:0] rdata;
    logic [7:0]   sw;
    int s, n, endAt, len, outcome;
    bit legal, reqOn;
    fwVec = FW;
    s = int'(slot);
    legal = (rd ^ wr) && (s < NSL);
    n = legal ? int'(fwVec[s*4 +: 4]) : 0;
    if (!legal) begin
      len = 0; outcome = 1;
    end else begin
      endAt = (n != 0) ? n : hsLow;
      if (withdrawAt > 0 && withdrawAt <= endAt && withdrawAt <= TO) begin
        len = withdrawAt - 1; outcome = 2;
      end else if (endAt <= TO) begin
        len = endAt; outcome = 0;
      end else begin
        len = TO; outcome = 1;
      end
    end
    for (int i = 0; i < NSL; i++) rdata[i*32 +: 32] = $urandom;
    if (s < NSL) rdata[s*32 +: 32] = slotData;
    releaseCyc = -1;
    for (int cyc = 0; cyc <= len + 1; cyc++) begin
      @(posedge clock);
      #1;
      reqOn = !(outcome == 2 && cyc == len + 1);
      m_read  = reqOn ? rd : 1'b0;
      m_write = reqOn ? wr : 1'b0;
      m_address = {slot, 28'($urandom)};
      s_readdata = rdata;
      sw = 8'($urandom);
      if (legal && n == 0) sw[s] = (cyc < hsLow);
      s_wait = sw;
      expRd = '0; expWr = '0; expFault = 1'b0;
      if (cyc >= 1 && cyc <= len) begin
        expRd[s] = rd;
        expWr[s] = wr;
      end
      if (cyc == 1 && (rd ^ wr)) modelCs = slot;
      if (cyc <= len) begin
        expWait = 1'b1;
      end else begin
        expWait = 1'b0;
        if (outcome == 0 && rd) modelData = rdata[s*32 +: 32];
        if (outcome == 1) begin
          expFault = 1'b1;
          modelData = '0;
          modelFc = (modelFc < 255) ? modelFc + 1 : 255;
        end
      end
      expValid = 1'b1;
      @(negedge clock);
      if (!m_wait && releaseCyc < 0) releaseCyc = cyc + 1;
    end
  endtask

  task automatic idleCycle();
    @(posedge clock);
    #1;
    m_read = 1'b0; m_write = 1'b0; s_wait = 8'($urandom);
    expRd = '0; expWr = '0; expWait = 1'b0; expFault = 1'b0; expValid = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rel, sc0, r, hs, wd;
    bit rd, wr;
    logic [3:0] slot;
    reset = 1'b1; m_read = 1'b0; m_write = 1'b0; m_address = '0;
    s_wait = '0; s_readdata = '0;
    modelCs = '0; modelData = '0; modelFc = 0;
    expRd = '0; expWr = '0; expWait = 1'b0; expFault = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_s_read", {24'd0, s_read}, 32'd0);
    checkOutput("reset_s_write", {24'd0, s_write}, 32'd0);
    checkOutput("reset_m_wait", {31'd0, m_wait}, 32'd0);
    checkOutput("reset_m_fault", {31'd0, m_fault}, 32'd0);
    checkOutput("reset_m_readdata", m_readdata, 32'd0);
    checkOutput("reset_chipselect", {28'd0, chipselect}, 32'd0);
    checkOutput("reset_fault_count", {24'd0, fault_count}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    sc0 = strobeCycles;
    applyStimulus(1'b1, 1'b0, 4'd2, 4, 0, 32'hDEADBEEF, rel);
    checkOutput("rd2_release_cycle", rel, 32'd6);
    checkOutput("rd2_strobe_cycles", strobeCycles - sc0, 32'd4);
    checkOutput("rd2_data", m_readdata, 32'hDEADBEEF);

    sc0 = strobeCycles;
    applyStimulus(1'b0, 1'b1, 4'd1, 1, 0, 32'h0BAD_F00D, rel);
    checkOutput("wr1_release_cycle", rel, 32'd5);
    checkOutput("wr1_strobe_cycles", strobeCycles - sc0, 32'd3);
    checkOutput("wr1_data_kept", m_readdata, 32'hDEADBEEF);

    sc0 = strobeCycles;
    applyStimulus(1'b1, 1'b0, 4'hF, 1, 0, 32'h1111_1111, rel);
    checkOutput("badslot_release_cycle", rel, 32'd2);
    checkOutput("badslot_strobes", strobeCycles - sc0, 32'd0);
    checkOutput("badslot_fault", {31'd0, m_fault}, 32'd1);
    checkOutput("badslot_data", m_readdata, 32'd0);
    checkOutput("badslot_count", {24'd0, fault_count}, 32'd1);

    for (int k = 0; k < 300; k++) begin
      sc0 = strobeCycles;
      applyStimulus(1'b1, 1'b0, 4'd4, 1000, 0, 32'h2222_2222, rel);
    end
    checkOutput("timeout_release_cycle", rel, 32'd18);
    checkOutput("timeout_strobe_cycles", strobeCycles - sc0, 32'd16);
    checkOutput("timeout_saturate", {24'd0, fault_count}, 32'd255);

    sc0 = strobeCycles;
    applyStimulus(1'b1, 1'b1, 4'd2, 1, 0, 32'h3333_3333, rel);
    checkOutput("both_strobes", strobeCycles - sc0, 32'd0);
    checkOutput("both_fault", {31'd0, m_fault}, 32'd1);

    sc0 = strobeCycles;
    applyStimulus(1'b1, 1'b0, 4'd3, 10, 3, 32'h4444_4444, rel);
    checkOutput("withdraw_strobes", strobeCycles - sc0, 32'd2);
    checkOutput("withdraw_no_fault", {31'd0, m_fault}, 32'd0);
    checkOutput("withdraw_count", {24'd0, fault_count}, 32'd255);

    // Reset pulled in the second ACCESS cycle of a read to slot 3.
    @(posedge clock);
    #1;
    expValid = 1'b0;
    m_address = {4'd3, 28'd0}; m_read = 1'b1; m_write = 1'b0; s_wait = 8'hFF;
    @(posedge clock);
    @(posedge clock);
    #2;
    checkOutput("rst_pre_strobe", {24'd0, s_read}, 32'h08);
    reset = 1'b1;
    #1;
    checkOutput("rst_s_read", {24'd0, s_read}, 32'd0);
    checkOutput("rst_s_write", {24'd0, s_write}, 32'd0);
    checkOutput("rst_m_wait", {31'd0, m_wait}, 32'd0);
    checkOutput("rst_m_fault", {31'd0, m_fault}, 32'd0);
    checkOutput("rst_m_readdata", m_readdata, 32'd0);
    checkOutput("rst_chipselect", {28'd0, chipselect}, 32'd0);
    checkOutput("rst_fault_count", {24'd0, fault_count}, 32'd0);
    modelCs = '0; modelData = '0; modelFc = 0;
    m_read = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'd3, 2, 0, 32'h1234_5678, rel);
    checkOutput("post_rst_release", rel, 32'd4);
    checkOutput("post_rst_data", m_readdata, 32'h1234_5678);

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 15);
      rd = (r == 0) || (r < 8);
      wr = (r == 0) || (r >= 8);
      slot = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      hs = $urandom_range(1, 20);
      wd = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8) : 0;
      applyStimulus(rd, wr, slot, hs, wd, $urandom, rel);
      if ($urandom_range(0, 3) == 0) idleCycle();
    end

    expValid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
